// File: rtl/game_pacer_pkg.sv
// game_pacer_pkg: shared state type, widths and period arithmetic for the game pacer.
package game_pacer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} pacer_state_t;
  localparam int SCORE_W = 8;
  localparam int LEVEL_W = 4;
  function automatic logic [7:0] calc_period(
    input logic [LEVEL_W-1:0] level,
    input logic [7:0]         base,
    input logic [7:0]         min_p,
    input logic [7:0]         step
  );
    logic [11:0] dec;
    dec = 12'(level) * 12'(step);
    return (dec + 12'(min_p) >= 12'(base)) ? min_p : 8'(12'(base) - dec);
  endfunction
endpackage

// File: rtl/game_pacer_divider.sv
// pacer_divider: prescaler producing one-cycle sub-tick pulses while enabled.
// Define PACER_BOOST_EN to add the boost input (advance by 2 per cycle).
module pacer_divider #(
  parameter logic [15:0] PRESCALE = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
`ifdef PACER_BOOST_EN
  input  logic boost,
`endif
  output logic tick
);
  logic [15:0] cnt;
  logic        tc;
  logic [15:0] inc;
  always_comb begin
`ifdef PACER_BOOST_EN
    tc  = boost ? cnt >= PRESCALE - 16'd2 : cnt == PRESCALE - 16'd1;
    inc = boost ? 16'd2 : 16'd1;
`else
    tc  = cnt == PRESCALE - 16'd1;
    inc = 16'd1;
`endif
    tick = enable & tc;
  end
  always_ff @(posedge clk)
    if (!rst_n || clear) cnt <= '0;
    else if (enable) cnt <= tc ? '0 : cnt + inc;
endmodule

// File: rtl/game_pacer.sv
// game_pacer: phase pacing, scoring and start/pause/over control for the snake game.
// Define PACER_BOOST_EN to add the i_boost double-speed input.
module game_pacer
  import game_pacer_pkg::*;
#(
  parameter logic [15:0] PRESCALE         = 16'd50000,
  parameter logic [7:0]  BASE_PERIOD      = 8'd20,
  parameter logic [7:0]  MIN_PERIOD       = 8'd4,
  parameter logic [7:0]  STEP             = 8'd2,
  parameter logic [3:0]  APPLES_PER_LEVEL = 4'd4,
  parameter logic [3:0]  MAX_LEVEL        = 4'd15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_restart,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_eat,
  input  logic               i_failure,
  input  logic               i_success,
`ifdef PACER_BOOST_EN
  input  logic               i_boost,
`endif
  output logic               o_phase,
  output logic [LEVEL_W-1:0] o_level,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_running
);
  pacer_state_t       state, state_d;
  logic               tick, last, eat_ok, ended, wrap;
  logic [7:0]         period_cnt, period_q;
  logic [LEVEL_W-1:0] apple_cnt;
  always_comb begin
    ended   = i_failure | i_success;
    eat_ok  = i_eat & (state == RUN | state == PAUSED);
    wrap    = apple_cnt == APPLES_PER_LEVEL - 4'd1;
    last    = tick & (period_cnt == period_q - 8'd1);
    state_d = state == IDLE ? (i_start ? RUN : IDLE) :
              state == OVER ? OVER :
              ended         ? OVER :
              i_pause       ? PAUSED : RUN;
  end
  pacer_divider #(.PRESCALE(PRESCALE)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state == RUN),
    .clear  (i_restart | state == IDLE),
`ifdef PACER_BOOST_EN
    .boost  (i_boost),
`endif
    .tick   (tick)
  );
  // restart leaves the phase line alone so the game sees no spurious step
  always_ff @(posedge clk)
    if (!rst_n) o_phase <= 1'b0;
    else if (!i_restart && last) o_phase <= ~o_phase;
  always_ff @(posedge clk)
    if (!rst_n || i_restart) begin
      state      <= IDLE;
      o_running  <= 1'b0;
      period_cnt <= '0;
      period_q   <= BASE_PERIOD;
      apple_cnt  <= '0;
      o_level    <= '0;
      o_score    <= '0;
    end else begin
      state      <= state_d;
      o_running  <= state_d == RUN;
      period_cnt <= (state == IDLE || last) ? '0 : tick ? period_cnt + 8'd1 : period_cnt;
      period_q   <= last ? calc_period(o_level, BASE_PERIOD, MIN_PERIOD, STEP) : period_q;
      if (eat_ok) begin
        o_score   <= o_score == '1 ? o_score : o_score + 1'b1;
        apple_cnt <= wrap ? '0 : apple_cnt + 1'b1;
        o_level   <= (wrap && o_level != MAX_LEVEL) ? o_level + 1'b1 : o_level;
      end
    end
endmodule

// File: tb/tb_game_pacer.sv
// tb_game_pacer: randomized self-checking bench for game_pacer against a cycle-budget model.
module tb_game_pacer;
  localparam int PS = 4, BP = 8, MP = 2, ST = 2, APL = 2, ML = 15;
  logic clk = 1'b0, rst_n = 1'b0, i_restart = 1'b0, i_start = 1'b0, i_pause = 1'b0;
  logic i_eat = 1'b0, i_failure = 1'b0, i_success = 1'b0, i_boost = 1'b0;
  logic o_phase, o_running;
  logic [3:0] o_level;
  logic [7:0] o_score;
  int checks = 0, failures = 0, cyc = 0;
  int m_state = 0, m_eaten = 0, m_score = 0, m_level = 0, m_elapsed = 0, m_len = PS * BP;
  logic m_phase = 1'b0;

  always #5 clk = ~clk;

  game_pacer #(
    .PRESCALE(16'd4), .BASE_PERIOD(8'd8), .MIN_PERIOD(8'd2), .STEP(8'd2),
    .APPLES_PER_LEVEL(4'd2), .MAX_LEVEL(4'd15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_restart(i_restart), .i_start(i_start), .i_pause(i_pause),
    .i_eat(i_eat), .i_failure(i_failure), .i_success(i_success),
`ifdef PACER_BOOST_EN
    .i_boost(i_boost),
`endif
    .o_phase(o_phase), .o_level(o_level), .o_score(o_score), .o_running(o_running)
  );

  function automatic int period_of(int lvl);
    int p = BP - lvl * ST;
    return p < MP ? MP : p;
  endfunction

  // model: each RUN cycle spends 1 unit of work (2 when boosted); a toggle costs PS*period units
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n || i_restart) begin
      m_state = 0; m_eaten = 0; m_score = 0; m_level = 0; m_elapsed = 0; m_len = PS * BP;
      if (!rst_n) m_phase = 1'b0;
    end else begin
      if (m_state == 1) begin
        m_elapsed += i_boost ? 2 : 1;
        if (m_elapsed >= m_len) begin
          m_phase = ~m_phase; m_elapsed = 0; m_len = PS * period_of(m_level);
        end
      end
      if ((m_state == 1 || m_state == 2) && i_eat) begin
        m_eaten++;
        m_score = m_score < 255 ? m_score + 1 : 255;
        m_level = m_eaten / APL > ML ? ML : m_eaten / APL;
      end
      if (m_state == 0) m_state = i_start ? 1 : 0;
      else if (m_state != 3) m_state = (i_failure || i_success) ? 3 : i_pause ? 2 : 1;
    end
  endtask

  task automatic wait_toggle(output int dt);
    logic p;
    p = o_phase;
    dt = 0;
    do begin step(); dt++; end while (o_phase === p && dt < 400);
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (o_phase !== 1'b0) begin failures++; $display("FAIL reset_phase got=%0b exp=0", o_phase); end
    checks++; if (o_level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", o_level); end
    checks++; if (o_score !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", o_score); end
    checks++; if (o_running !== 1'b0) begin failures++; $display("FAIL reset_running got=%0b exp=0", o_running); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_start();
    int dt;
    i_start = 1'b1; step(); i_start = 1'b0;
    checks++; if (o_running !== 1'b1) begin failures++; $display("FAIL start_running got=%0b exp=1", o_running); end
    wait_toggle(dt);
    checks++; if (dt !== PS * BP) begin failures++; $display("FAIL first_toggle got=%0d exp=%0d", dt, PS * BP); end
    wait_toggle(dt);
    checks++; if (dt !== PS * BP) begin failures++; $display("FAIL second_toggle got=%0d exp=%0d", dt, PS * BP); end
    checks++; if (o_phase !== m_phase) begin failures++; $display("FAIL start_phase_model got=%0b exp=%0b", o_phase, m_phase); end
  endtask

  task automatic test_eat_levels();
    int dt, ps;
    ps = cyc;
    repeat ($urandom_range(1, 10)) step();
    i_eat = 1'b1; step(); i_eat = 1'b0;
    repeat ($urandom_range(1, 10)) step();
    i_eat = 1'b1; step(); i_eat = 1'b0;
    checks++; if (o_score !== 8'd2) begin failures++; $display("FAIL eat2_score got=%0d exp=2", o_score); end
    checks++; if (o_level !== 4'd1) begin failures++; $display("FAIL eat2_level got=%0d exp=1", o_level); end
    wait_toggle(dt);
    checks++; if (cyc - ps !== PS * BP) begin failures++; $display("FAIL period_in_progress got=%0d exp=%0d", cyc - ps, PS * BP); end
    wait_toggle(dt);
    checks++; if (dt !== PS * period_of(1)) begin failures++; $display("FAIL level1_period got=%0d exp=%0d", dt, PS * period_of(1)); end
    ps = cyc;
    repeat (4) begin
      repeat ($urandom_range(0, 2)) step();
      i_eat = 1'b1; step(); i_eat = 1'b0;
    end
    wait_toggle(dt);
    checks++; if (cyc - ps !== PS * period_of(1)) begin failures++; $display("FAIL level1_tail got=%0d exp=%0d", cyc - ps, PS * period_of(1)); end
    checks++; if (o_level !== 4'd3) begin failures++; $display("FAIL eat6_level got=%0d exp=3", o_level); end
    wait_toggle(dt);
    checks++; if (dt !== PS * MP) begin failures++; $display("FAIL level3_period got=%0d exp=%0d", dt, PS * MP); end
    i_eat = 1'b1; repeat (4) step(); i_eat = 1'b0;
    wait_toggle(dt);
    wait_toggle(dt);
    checks++; if (dt !== PS * MP) begin failures++; $display("FAIL level5_period got=%0d exp=%0d", dt, PS * MP); end
    checks++; if (o_level !== 4'd5) begin failures++; $display("FAIL eat10_level got=%0d exp=5", o_level); end
    checks++; if (o_score !== 8'd10) begin failures++; $display("FAIL eat10_score got=%0d exp=10", o_score); end
    checks++; if (o_phase !== m_phase) begin failures++; $display("FAIL levels_phase_model got=%0b exp=%0b", o_phase, m_phase); end
  endtask

  task automatic test_pause();
    int dt, ps, moved;
    logic ph;
    wait_toggle(dt);
    ps = cyc;
    repeat ($urandom_range(1, 5)) step();
    ph = o_phase;
    moved = 0;
    i_pause = 1'b1;
    for (int i = 0; i < 100; i++) begin
      i_eat = (i == 50);
      step();
      if (o_phase !== ph) moved++;
    end
    i_eat = 1'b0;
    checks++; if (moved !== 0) begin failures++; $display("FAIL pause_toggles got=%0d exp=0", moved); end
    checks++; if (o_running !== 1'b0) begin failures++; $display("FAIL pause_running got=%0b exp=0", o_running); end
    checks++; if (o_score !== 8'(m_score)) begin failures++; $display("FAIL pause_eat_score got=%0d exp=%0d", o_score, m_score); end
    i_pause = 1'b0;
    wait_toggle(dt);
    checks++; if (cyc - ps !== PS * MP + 100) begin failures++; $display("FAIL pause_resume got=%0d exp=%0d", cyc - ps, PS * MP + 100); end
    checks++; if (o_running !== 1'b1) begin failures++; $display("FAIL resume_running got=%0b exp=1", o_running); end
  endtask

  task automatic test_over();
    int dt, moved;
    logic [7:0] sc;
    logic ph;
    repeat ($urandom_range(1, 6)) step();
    sc = o_score;
    i_eat = 1'b1; i_failure = 1'b1; step(); i_eat = 1'b0;
    checks++; if (o_score !== sc + 8'd1) begin failures++; $display("FAIL over_score got=%0d exp=%0d", o_score, sc + 8'd1); end
    checks++; if (o_running !== 1'b0) begin failures++; $display("FAIL over_running got=%0b exp=0", o_running); end
    ph = o_phase;
    moved = 0;
    for (int i = 0; i < 60; i++) begin
      i_start = (i % 7 == 0);
      i_eat = (i % 5 == 0);
      step();
      if (o_phase !== ph || o_running !== 1'b0) moved++;
    end
    i_start = 1'b0; i_eat = 1'b0;
    checks++; if (moved !== 0) begin failures++; $display("FAIL over_frozen got=%0d exp=0", moved); end
    checks++; if (o_score !== sc + 8'd1) begin failures++; $display("FAIL over_eat_ignored got=%0d exp=%0d", o_score, sc + 8'd1); end
    i_restart = 1'b1; step(); i_restart = 1'b0; i_failure = 1'b0;
    checks++; if (o_score !== 8'd0) begin failures++; $display("FAIL restart_score got=%0d exp=0", o_score); end
    checks++; if (o_level !== 4'd0) begin failures++; $display("FAIL restart_level got=%0d exp=0", o_level); end
    checks++; if (o_phase !== ph) begin failures++; $display("FAIL restart_phase got=%0b exp=%0b", o_phase, ph); end
    i_start = 1'b1; step(); i_start = 1'b0;
    wait_toggle(dt);
    checks++; if (dt !== PS * BP) begin failures++; $display("FAIL restart_first_toggle got=%0d exp=%0d", dt, PS * BP); end
  endtask

  task automatic test_saturation();
    i_eat = 1'b1;
    for (int i = 0; i < 270; i++) begin
      step();
      checks++; if (o_phase !== m_phase) begin failures++; $display("FAIL sat_phase cyc=%0d got=%0b exp=%0b", cyc, o_phase, m_phase); end
    end
    i_eat = 1'b0;
    checks++; if (o_score !== 8'd255) begin failures++; $display("FAIL sat_score got=%0d exp=255", o_score); end
    checks++; if (o_level !== 4'(ML)) begin failures++; $display("FAIL sat_level got=%0d exp=%0d", o_level, ML); end
  endtask

  task automatic test_success();
    i_restart = 1'b1; step(); i_restart = 1'b0;
    i_eat = 1'b1; step(); i_eat = 1'b0;
    checks++; if (o_score !== 8'd0) begin failures++; $display("FAIL idle_eat_ignored got=%0d exp=0", o_score); end
    i_start = 1'b1; step(); i_start = 1'b0;
    i_eat = 1'b1; step(); i_eat = 1'b0;
    i_success = 1'b1; i_pause = 1'b1; step(); i_pause = 1'b0;
    step();
    checks++; if (o_running !== 1'b0) begin failures++; $display("FAIL success_running got=%0b exp=0", o_running); end
    i_eat = 1'b1; step(); i_eat = 1'b0;
    checks++; if (o_score !== 8'(m_score)) begin failures++; $display("FAIL success_score got=%0d exp=%0d", o_score, m_score); end
    i_restart = 1'b1; step(); i_restart = 1'b0; i_success = 1'b0;
  endtask

`ifdef PACER_BOOST_EN
  task automatic test_boost();
    int dt;
    i_boost = 1'b1;
    i_start = 1'b1; step(); i_start = 1'b0;
    wait_toggle(dt);
    checks++; if (dt !== PS * BP / 2) begin failures++; $display("FAIL boost_first got=%0d exp=%0d", dt, PS * BP / 2); end
    wait_toggle(dt);
    checks++; if (dt !== PS * BP / 2) begin failures++; $display("FAIL boost_second got=%0d exp=%0d", dt, PS * BP / 2); end
    i_boost = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_eat_levels();
    test_pause();
    test_over();
    test_saturation();
    test_success();
`ifdef PACER_BOOST_EN
    test_boost();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
